// File: rtl/tpu_vadd_pkg.sv
// Shared types and constants for the BRAM vector-add engine.
package tpu_vadd_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 13;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned MAX_READ_LATENCY   = 2;

   typedef enum logic [2:0] {
      StIdle,
      StRdA,
      StRdB,
      StWait,
      StWr,
      StDone
   } vadd_state_e;

endpackage

// File: rtl/vadd_alu.sv
// Combinational element adder; wraps by default, saturates (signed) when VADD_SAT_EN is defined.
// ovf_o flags signed two's-complement overflow of the raw sum.
module vadd_alu
   import tpu_vadd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] sum_o,
   output logic                  ovf_o
);

   localparam int unsigned Msb = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] raw;

   always_comb begin
      raw   = a_i + b_i;
      ovf_o = (a_i[Msb] == b_i[Msb]) && (raw[Msb] != a_i[Msb]);
`ifdef VADD_SAT_EN
      if (ovf_o) begin
         // Clamp toward the sign of the operands.
         sum_o = a_i[Msb] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         sum_o = raw;
      end
`else
      sum_o = raw;
`endif
   end

endmodule

// File: rtl/bram_vadd_engine.sv
// Port B master: reads A[i], B[i], writes C[i] = A[i] + B[i]; pulses done when finished.
// Optional VADD_SAT_EN build selects saturating add and exposes a sticky sat_flag.
module bram_vadd_engine
   import tpu_vadd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_a_addr,
   input  logic [ADDR_WIDTH-1:0] src_b_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [31:0]           len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] comp_addr_b,
   output logic [DATA_WIDTH-1:0] comp_din_b,
   input  logic [DATA_WIDTH-1:0] comp_dout_b,
   output logic                  comp_en_b,
   output logic                  comp_we_b
`ifdef VADD_SAT_EN
   ,output logic                 sat_flag
`endif
);

   localparam int unsigned LatW = $clog2(MAX_READ_LATENCY);

   vadd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d, ptr_c_q, ptr_c_d;
   logic [31:0]             len_q, len_d, elem_cnt_q, elem_cnt_d;
   logic [LatW-1:0]         lat_cnt_q, lat_cnt_d;
   logic [READ_LATENCY-1:0] tag_a_q, tag_a_d, tag_b_q, tag_b_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d, sum_q, sum_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    en_q, en_d, we_q, we_d, done_q, done_d, busy_q, busy_d;
   logic [DATA_WIDTH-1:0]   alu_sum;

`ifdef VADD_SAT_EN
   logic alu_ovf;
   logic sat_flag_q, sat_flag_d;
`else
   logic unused_alu_ovf;
`endif

   vadd_alu #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_alu (
      .a_i  (a_q),
      .b_i  (comp_dout_b),
      .sum_o(alu_sum),
`ifdef VADD_SAT_EN
      .ovf_o(alu_ovf)
`else
      .ovf_o(unused_alu_ovf)
`endif
   );

   always_comb begin
      state_d    = state_q;
      ptr_a_d    = ptr_a_q;
      ptr_b_d    = ptr_b_q;
      ptr_c_d    = ptr_c_q;
      len_d      = len_q;
      elem_cnt_d = elem_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      a_d        = a_q;
      sum_d      = sum_q;
`ifdef VADD_SAT_EN
      sat_flag_d = sat_flag_q;
`endif

      // Read-return tags follow the issue cycle through a delay line matching the BRAM latency.
      tag_a_d    = '0;
      tag_b_d    = '0;
      tag_a_d[0] = (state_q == StRdA);
      tag_b_d[0] = (state_q == StRdB);
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         tag_a_d[i] = tag_a_q[i-1];
         tag_b_d[i] = tag_b_q[i-1];
      end

      if (tag_a_q[READ_LATENCY-1]) begin
         a_d = comp_dout_b;
      end
      if (tag_b_q[READ_LATENCY-1]) begin
         sum_d = alu_sum;
`ifdef VADD_SAT_EN
         sat_flag_d = sat_flag_q | alu_ovf;
`endif
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               ptr_a_d    = src_a_addr;
               ptr_b_d    = src_b_addr;
               ptr_c_d    = dst_addr;
               len_d      = len;
               elem_cnt_d = '0;
`ifdef VADD_SAT_EN
               sat_flag_d = 1'b0;
`endif
               state_d    = (len == 32'd0) ? StDone : StRdA;
            end
         end
         StRdA: state_d = StRdB;
         StRdB: begin
            lat_cnt_d = '0;
            state_d   = StWait;
         end
         StWait: begin
            if (lat_cnt_q == LatW'(READ_LATENCY - 1)) begin
               state_d = StWr;
            end else begin
               lat_cnt_d = lat_cnt_q + LatW'(1);
            end
         end
         StWr: begin
            ptr_a_d    = ptr_a_q + ADDR_WIDTH'(1);
            ptr_b_d    = ptr_b_q + ADDR_WIDTH'(1);
            ptr_c_d    = ptr_c_q + ADDR_WIDTH'(1);
            elem_cnt_d = elem_cnt_q + 32'd1;
            state_d    = (elem_cnt_q == len_q - 32'd1) ? StDone : StRdA;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q.
      en_d   = (state_d == StRdA) || (state_d == StRdB) || (state_d == StWr);
      we_d   = (state_d == StWr);
      done_d = (state_d == StDone);
      busy_d = (state_d != StIdle);
      case (state_d)
         StRdA:   addr_d = ptr_a_d;
         StRdB:   addr_d = ptr_b_d;
         StWr:    addr_d = ptr_c_d;
         default: addr_d = addr_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ptr_a_q    <= '0;
         ptr_b_q    <= '0;
         ptr_c_q    <= '0;
         len_q      <= '0;
         elem_cnt_q <= '0;
         lat_cnt_q  <= '0;
         tag_a_q    <= '0;
         tag_b_q    <= '0;
         a_q        <= '0;
         sum_q      <= '0;
         addr_q     <= '0;
         en_q       <= 1'b0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef VADD_SAT_EN
         sat_flag_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_a_q    <= ptr_a_d;
         ptr_b_q    <= ptr_b_d;
         ptr_c_q    <= ptr_c_d;
         len_q      <= len_d;
         elem_cnt_q <= elem_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         tag_a_q    <= tag_a_d;
         tag_b_q    <= tag_b_d;
         a_q        <= a_d;
         sum_q      <= sum_d;
         addr_q     <= addr_d;
         en_q       <= en_d;
         we_q       <= we_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
`ifdef VADD_SAT_EN
         sat_flag_q <= sat_flag_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign comp_addr_b = addr_q;
   assign comp_din_b  = sum_q;
   assign comp_en_b   = en_q;
   assign comp_we_b   = we_q;
`ifdef VADD_SAT_EN
   assign sat_flag    = sat_flag_q;
`endif

endmodule

// File: tb/tb_bram_vadd_engine.sv
// Scoreboard bench: two engines (read latency 1 and 2), each with its own BRAM model.
`timescale 1ns/1ps
module tb_bram_vadd_engine;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int NI = 2;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            rel;
   } acc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n [NI];
   logic          start [NI];
   logic [AW-1:0] src_a [NI];
   logic [AW-1:0] src_b [NI];
   logic [AW-1:0] dst   [NI];
   logic [31:0]   len   [NI];
   logic          busy  [NI];
   logic          done  [NI];
   logic [AW-1:0] addr  [NI];
   logic [DW-1:0] din   [NI];
   logic [DW-1:0] dout  [NI];
   logic          en    [NI];
   logic          we    [NI];
`ifdef VADD_SAT_EN
   logic          sat   [NI];
`endif

   logic [DW-1:0] mem [NI][8192];
   logic [DW-1:0] p1  [NI];
   logic [DW-1:0] p2  [NI];
   logic          ld_en;
   int            ld_idx;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   start_cyc [NI];
   int   done_cnt  [NI];
   acc_t q0[$];
   acc_t q1[$];
   int   dq0[$];
   int   dq1[$];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      bram_vadd_engine #(
         .ADDR_WIDTH  (AW),
         .DATA_WIDTH  (DW),
         .READ_LATENCY(g + 1)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n[g]),
         .start      (start[g]),
         .src_a_addr (src_a[g]),
         .src_b_addr (src_b[g]),
         .dst_addr   (dst[g]),
         .len        (len[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .comp_addr_b(addr[g]),
         .comp_din_b (din[g]),
         .comp_dout_b(dout[g]),
         .comp_en_b  (en[g]),
         .comp_we_b  (we[g])
`ifdef VADD_SAT_EN
         ,.sat_flag  (sat[g])
`endif
      );
      assign dout[g] = (g == 0) ? p1[g] : p2[g];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < NI; g++) begin
         if (ld_en && ld_idx == g) mem[g][ld_addr] <= ld_data;
         else if (en[g] && we[g]) mem[g][addr[g]] <= din[g];
         if (en[g] && !we[g]) p1[g] <= mem[g][addr[g]];
         p2[g] <= p1[g];
      end
   end

   function automatic int rl_of(input int idx);
      return idx + 1;
   endfunction

   function automatic int pending(input int idx);
      return (idx == 0) ? (q0.size() + dq0.size()) : (q1.size() + dq1.size());
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic push_acc(input int idx, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int rel);
      acc_t e;
      e.we = w; e.addr = a; e.data = d; e.rel = rel;
      if (idx == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic push_elem(input int idx, input int k, input logic [AW-1:0] aa,
                            input logic [AW-1:0] ba, input logic [AW-1:0] ca,
                            input logic [DW-1:0] d);
      int base;
      base = 1 + k * (rl_of(idx) + 3);
      push_acc(idx, 1'b0, aa, '0, base);
      push_acc(idx, 1'b0, ba, '0, base + 1);
      push_acc(idx, 1'b1, ca, d, base + rl_of(idx) + 2);
   endtask

   task automatic mon_acc(input int g);
      acc_t e;
      int   rel;
      bit   have;
      rel  = cyc - start_cyc[g];
      have = (g == 0) ? (q0.size() > 0) : (q1.size() > 0);
      checks++;
      if (!have) begin
         failures++;
         $display("FAIL access[%0d]: got we=%0b addr=%h rel=%0d, required no access",
                  g, we[g], addr[g], rel);
      end else begin
         if (g == 0) e = q0.pop_front();
         else e = q1.pop_front();
         if (we[g] !== e.we || addr[g] !== e.addr || rel != e.rel ||
             (e.we && din[g] !== e.data)) begin
            failures++;
            $display("FAIL access[%0d]: got we=%0b addr=%h din=%h rel=%0d, required we=%0b addr=%h din=%h rel=%0d",
                     g, we[g], addr[g], din[g], rel, e.we, e.addr, e.data, e.rel);
         end
      end
   endtask

   task automatic mon_done(input int g);
      int rel;
      int e;
      rel = cyc - start_cyc[g];
      done_cnt[g]++;
      checks++;
      if (pending(g) == ((g == 0) ? q0.size() : q1.size())) begin
         failures++;
         $display("FAIL done[%0d]: got pulse at rel=%0d, required none", g, rel);
      end else begin
         if (g == 0) e = dq0.pop_front();
         else e = dq1.pop_front();
         if (rel != e) begin
            failures++;
            $display("FAIL done[%0d]: got rel=%0d required rel=%0d", g, rel, e);
         end
      end
   endtask

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (en[g] === 1'b1) mon_acc(g);
         if (done[g] === 1'b1) mon_done(g);
      end
   end

   task automatic poke(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_idx = idx; ld_addr = a; ld_data = d; ld_en = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // Issue one run, wait for done (bounded), check busy and drained scoreboard.
   task automatic run(input int idx, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] c, input logic [31:0] n, input int exp_done,
                      input int restart_rel);
      bit got_done;
      bit busy_bad;
      int d0;
      src_a[idx] = a; src_b[idx] = b; dst[idx] = c; len[idx] = n;
      start[idx] = 1'b1;
      start_cyc[idx] = cyc;
      d0 = done_cnt[idx];
      if (idx == 0) dq0.push_back(exp_done);
      else dq1.push_back(exp_done);
      @(posedge clk); #1;
      start[idx] = 1'b0;
      src_a[idx] = ~a; src_b[idx] = ~b; dst[idx] = ~c; len[idx] = 32'd5;
      got_done = 1'b0;
      busy_bad = 1'b0;
      for (int t = 1; t <= 400 && !got_done; t++) begin
         @(negedge clk);
         if (busy[idx] !== 1'b1) busy_bad = 1'b1;
         if (done[idx] === 1'b1) got_done = 1'b1;
         start[idx] = (t == restart_rel);
      end
      start[idx] = 1'b0;
      check("done_seen", got_done, 1);
      check("busy_during_run", busy_bad, 0);
      @(posedge clk); #1;
      check("busy_after_done", busy[idx], 0);
      check("done_count", done_cnt[idx] - d0, 1);
      check("scoreboard_drained", pending(idx), 0);
   endtask

   logic [DW-1:0] ea [4];
   logic [DW-1:0] eb [4];

   initial begin
      int s;
      int d0;
      ld_en = 1'b0; ld_idx = 0; ld_addr = '0; ld_data = '0;
      for (int g = 0; g < NI; g++) begin
         rst_n[g] = 1'b0; start[g] = 1'b0; src_a[g] = '0; src_b[g] = '0;
         dst[g] = '0; len[g] = '0; start_cyc[g] = 0; done_cnt[g] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         check("reset_busy", busy[g], 0);
         check("reset_done", done[g], 0);
         check("reset_en", en[g], 0);
         check("reset_we", we[g], 0);
         check("reset_addr", addr[g], 0);
         check("reset_din", din[g], 0);
`ifdef VADD_SAT_EN
         check("reset_sat", sat[g], 0);
`endif
         rst_n[g] = 1'b1;
      end
      @(posedge clk); #1;

      // Basic len=4 run, latency 1.
      ea = '{32'd1, 32'd2, 32'd3, 32'd4};
      eb = '{32'd10, 32'd20, 32'd30, 32'd40};
      for (int k = 0; k < 4; k++) begin
         poke(0, AW'(k), ea[k]);
         poke(0, AW'(13'h100 + k), eb[k]);
      end
      push_elem(0, 0, 13'h000, 13'h100, 13'h200, 32'd11);
      push_elem(0, 1, 13'h001, 13'h101, 13'h201, 32'd22);
      push_elem(0, 2, 13'h002, 13'h102, 13'h202, 32'd33);
      push_elem(0, 3, 13'h003, 13'h103, 13'h203, 32'd44);
      run(0, 13'h000, 13'h100, 13'h200, 32'd4, 17, -1);
      check("c0", mem[0][13'h200], 32'd11);
      check("c3", mem[0][13'h203], 32'd44);

      // len=0: no BRAM traffic, immediate done, memory untouched.
      run(0, 13'h000, 13'h100, 13'h200, 32'd0, 1, -1);
      check("len0_c1", mem[0][13'h201], 32'd22);
      check("len0_c2", mem[0][13'h202], 32'd33);

      // Data wrap: 0xFFFFFFFF + 2.
      poke(0, 13'h400, 32'hFFFF_FFFF);
      poke(0, 13'h401, 32'h0000_0002);
      push_elem(0, 0, 13'h400, 13'h401, 13'h402, 32'h0000_0001);
      run(0, 13'h400, 13'h401, 13'h402, 32'd1, 5, -1);
`ifdef VADD_SAT_EN
      check("sat_clear", sat[0], 0);
`endif

      // Signed overflow corners.
      poke(0, 13'h410, 32'h7FFF_FFFF);
      poke(0, 13'h411, 32'h8000_0000);
      poke(0, 13'h420, 32'h0000_0001);
      poke(0, 13'h421, 32'hFFFF_FFFF);
`ifdef VADD_SAT_EN
      push_elem(0, 0, 13'h410, 13'h420, 13'h430, 32'h7FFF_FFFF);
      push_elem(0, 1, 13'h411, 13'h421, 13'h431, 32'h8000_0000);
`else
      push_elem(0, 0, 13'h410, 13'h420, 13'h430, 32'h8000_0000);
      push_elem(0, 1, 13'h411, 13'h421, 13'h431, 32'h7FFF_FFFF);
`endif
      run(0, 13'h410, 13'h420, 13'h430, 32'd2, 9, -1);
`ifdef VADD_SAT_EN
      check("sat_set", sat[0], 1);
`endif

      // Address wrap with overlapping in-place chain, on both latencies.
      for (int g = 0; g < NI; g++) begin
         poke(g, 13'h1FFE, 32'd100);
         poke(g, 13'h1FFF, 32'd200);
         poke(g, 13'h0000, 32'd1);
         poke(g, 13'h0001, 32'd2);
         poke(g, 13'h0002, 32'd3);
         push_elem(g, 0, 13'h1FFE, 13'h0000, 13'h1FFF, 32'd101);
         push_elem(g, 1, 13'h1FFF, 13'h0001, 13'h0000, 32'd103);
         push_elem(g, 2, 13'h0000, 13'h0002, 13'h0001, 32'd106);
         run(g, 13'h1FFE, 13'h0000, 13'h1FFF, 32'd3, (g == 0) ? 13 : 16, -1);
         check("wrap_c2", mem[g][13'h0001], 32'd106);
      end

      // In-place dst == src_a, len=8, with an ignored second start mid-run.
      for (int k = 0; k < 8; k++) begin
         poke(0, AW'(13'h500 + k), DW'(100 * (k + 1)));
         poke(0, AW'(13'h600 + k), DW'(k + 1));
         push_elem(0, k, AW'(13'h500 + k), AW'(13'h600 + k), AW'(13'h500 + k),
                   DW'(101 * (k + 1)));
      end
      run(0, 13'h500, 13'h600, 13'h500, 32'd8, 33, 6);
      for (int k = 0; k < 8; k += 3) begin
         check("inplace", mem[0][13'h500 + k], DW'(101 * (k + 1)));
      end

      // Reset in WAIT of element 2 aborts: C[0..1] written, C[2..3] untouched.
      for (int k = 0; k < 4; k++) begin
         poke(0, AW'(13'h700 + k), DW'(k + 1));
         poke(0, AW'(13'h710 + k), DW'(k + 5));
         poke(0, AW'(13'h720 + k), 32'hDEAD_BEEF);
      end
      src_a[0] = 13'h700; src_b[0] = 13'h710; dst[0] = 13'h720; len[0] = 32'd4;
      start[0] = 1'b1;
      start_cyc[0] = cyc;
      s = cyc;
      d0 = done_cnt[0];
      push_elem(0, 0, 13'h700, 13'h710, 13'h720, 32'd6);
      push_elem(0, 1, 13'h701, 13'h711, 13'h721, 32'd8);
      push_acc(0, 1'b0, 13'h702, '0, 9);
      push_acc(0, 1'b0, 13'h712, '0, 10);
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_at_wait", cyc - s, 11);
      rst_n[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_en", en[0], 0);
      check("abort_we", we[0], 0);
      check("abort_busy", busy[0], 0);
      @(posedge clk); #1;
      rst_n[0] = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_drained", pending(0), 0);
      check("abort_no_done", done_cnt[0] - d0, 0);
      check("abort_c1", mem[0][13'h721], 32'd8);
      check("abort_c2", mem[0][13'h722], 32'hDEAD_BEEF);
      check("abort_c3", mem[0][13'h723], 32'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
